s3_twiddle_mul: RTL and testbench

Twiddle-factor multiplier between FFT stage 3 and stage 4 of the 32-point radix-2 SDF pipeline. It takes the 14-bit complex butterfly output of stage 3 and tracks the 8-sample butterfly phase with its own counter. Each sample is multiplied by W8^m from a small twiddle ROM. The result is rounded and saturated back to 14 bits for stage 4, through a 2-cycle pipeline with a matching valid flag.

---
 rtl/s3_twiddle_mul_if.sv | 27 ++
 rtl/s3_twiddle_mul.sv | 116 +++++++++++
 tb/tb_s3_twiddle_mul.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/s3_twiddle_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : s3_twiddle_mul_if
// Brief    : Sample bus between FFT stage 3 and the stage 3/4 twiddle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface s3_twiddle_mul_if #(
  parameter int DATA_W = 14
);
  logic                     cnt_en;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     out_valid;

  modport master (
    output cnt_en, in_real, in_imag,
    input  out_real, out_imag, out_valid
  );

  modport slave (
    input  cnt_en, in_real, in_imag,
    output out_real, out_imag, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/s3_twiddle_mul.sv
`default_nettype none
// ============================================================================
// Module   : s3_twiddle_mul
// Brief    : W8^m twiddle multiply between FFT stages 3 and 4, round + saturate,
//            two-cycle pipeline with a matching valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module s3_twiddle_mul #(
  parameter int DATA_W  = 14,
  parameter int TW_W    = 10,
  parameter int TW_FRAC = 8
) (
  input wire              clk,
  input wire              rst,
  s3_twiddle_mul_if.slave bus
);

  localparam int PROD_W = DATA_W + TW_W + 1;

  localparam logic signed [TW_W-1:0]   C_TW_ONE   = TW_W'(2 ** TW_FRAC);
  localparam logic signed [TW_W-1:0]   C_TW_ZERO  = '0;
  localparam logic signed [TW_W-1:0]   C_TW_R2P   = TW_W'(181);
  localparam logic signed [TW_W-1:0]   C_TW_R2N   = TW_W'(-181);
  localparam logic signed [TW_W-1:0]   C_TW_NONE  = TW_W'(-(2 ** TW_FRAC));
  localparam logic signed [PROD_W-1:0] C_ROUND    = PROD_W'(2 ** (TW_FRAC - 1));
  localparam logic signed [PROD_W-1:0] C_SAT_HI   = PROD_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] C_SAT_LO   = PROD_W'(-(2 ** (DATA_W - 1)));

  logic [2:0]               k_q, k_d;
  logic signed [DATA_W-1:0] ar_q, ai_q;
  logic signed [TW_W-1:0]   wr_q, wi_q;
  logic                     va_q;
  logic signed [DATA_W-1:0] or_q, oi_q;
  logic                     ov_q;

  logic signed [TW_W-1:0]   w_tw_re, w_tw_im;
  logic signed [PROD_W-1:0] w_pr, w_pi, w_pr_rnd, w_pi_rnd;
  logic signed [DATA_W-1:0] w_sat_re, w_sat_im;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PROD_W-1:0] v);
    if (v > C_SAT_HI) begin
      return DATA_W'(C_SAT_HI);
    end else if (v < C_SAT_LO) begin
      return DATA_W'(C_SAT_LO);
    end
    return DATA_W'(v);
  endfunction

  // Phase counter only advances on qualified samples, so gaps keep the phase.
  always_comb begin
    k_d = bus.cnt_en ? k_q + 3'd1 : k_q;
  end

  always_comb begin
    w_tw_re = C_TW_ONE;
    w_tw_im = C_TW_ZERO;
    case (k_q)
      3'd5: begin
        w_tw_re = C_TW_R2P;
        w_tw_im = C_TW_R2N;
      end
      3'd6: begin
        w_tw_re = C_TW_ZERO;
        w_tw_im = C_TW_NONE;
      end
      3'd7: begin
        w_tw_re = C_TW_R2N;
        w_tw_im = C_TW_R2N;
      end
      default: begin
        w_tw_re = C_TW_ONE;
        w_tw_im = C_TW_ZERO;
      end
    endcase
  end

  // Full-precision product, round-half-up, then clamp to the output range.
  always_comb begin
    w_pr     = PROD_W'(ar_q) * PROD_W'(wr_q) - PROD_W'(ai_q) * PROD_W'(wi_q);
    w_pi     = PROD_W'(ar_q) * PROD_W'(wi_q) + PROD_W'(ai_q) * PROD_W'(wr_q);
    w_pr_rnd = (w_pr + C_ROUND) >>> TW_FRAC;
    w_pi_rnd = (w_pi + C_ROUND) >>> TW_FRAC;
    w_sat_re = sat(w_pr_rnd);
    w_sat_im = sat(w_pi_rnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      ar_q <= '0;
      ai_q <= '0;
      wr_q <= '0;
      wi_q <= '0;
      va_q <= 1'b0;
      or_q <= '0;
      oi_q <= '0;
      ov_q <= 1'b0;
    end else begin
      k_q  <= k_d;
      ar_q <= bus.in_real;
      ai_q <= bus.in_imag;
      wr_q <= w_tw_re;
      wi_q <= w_tw_im;
      va_q <= bus.cnt_en;
      or_q <= w_sat_re;
      oi_q <= w_sat_im;
      ov_q <= va_q;
    end
  end

  assign bus.out_real  = or_q;
  assign bus.out_imag  = oi_q;
  assign bus.out_valid = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_s3_twiddle_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_s3_twiddle_mul
// Brief    : Self-checking bench for s3_twiddle_mul against a cycle-indexed model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_s3_twiddle_mul;

  localparam int DATA_W = 14;
  localparam int NCYC   = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   k_m    = 0;

  // Expected output visible during cycle n: valid flag, "must be zero" flag, data.
  logic                     ev [NCYC];
  logic                     ez [NCYC];
  logic signed [DATA_W-1:0] er [NCYC];
  logic signed [DATA_W-1:0] ei [NCYC];

  int tw_re [8] = '{256, 256, 256, 256, 256, 181, 0, -181};
  int tw_im [8] = '{0, 0, 0, 0, 0, -181, -256, -181};

  s3_twiddle_mul_if #(.DATA_W(DATA_W)) bus ();

  s3_twiddle_mul #(
    .DATA_W (DATA_W),
    .TW_W   (10),
    .TW_FRAC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [DATA_W-1:0] rnd_sat(input longint p);
    longint q;
    q = (p + 128) >>> 8;
    if (q > 8191) q = 8191;
    else if (q < -8192) q = -8192;
    return DATA_W'(q);
  endfunction

  function automatic int rnd_s();
    case ($urandom_range(0, 7))
      0:       return -8192;
      1:       return 8191;
      2:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom_range(0, 16383)) - 8192;
    endcase
  endfunction

  // Present one cycle of stimulus, record what it implies two cycles later, advance.
  task automatic tick(input logic r, input logic en, input int re, input int im);
    if (cyc + 3 >= NCYC) begin
      errors++;
      $display("FAIL cycle_budget cyc=%0d limit %0d", cyc, NCYC);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "cycle budget exhausted");
    end
    rst         = r;
    bus.cnt_en  = en;
    bus.in_real = DATA_W'(re);
    bus.in_imag = DATA_W'(im);
    if (r) begin
      k_m = 0;
      for (int d = 1; d <= 2; d++) begin
        ev[cyc+d] = 1'b0;
        ez[cyc+d] = 1'b1;
        er[cyc+d] = '0;
        ei[cyc+d] = '0;
      end
    end else begin
      ev[cyc+2] = en;
      ez[cyc+2] = 1'b0;
      er[cyc+2] = rnd_sat(longint'(re) * tw_re[k_m] - longint'(im) * tw_im[k_m]);
      ei[cyc+2] = rnd_sat(longint'(re) * tw_im[k_m] + longint'(im) * tw_re[k_m]);
      if (en) k_m = (k_m + 1) % 8;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      tick(n < 2, 1'b0, 123, -45);
      checks++;
      if (bus.out_valid !== ev[cyc] || bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got v=%b (%0d,%0d) exp v=%b (%0d,%0d)", cyc,
                 bus.out_valid, bus.out_real, bus.out_imag, ev[cyc], er[cyc], ei[cyc]);
      end
    end
  endtask

  task automatic test_trivial();
    for (int n = 0; n < 10; n++) begin
      if (n < 8) tick(1'b0, 1'b1, 1000, -300);
      else tick(1'b0, 1'b0, 0, 0);
      checks++;
      if (bus.out_valid !== ev[cyc]) begin
        errors++;
        $display("FAIL trivial_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, ev[cyc]);
      end
      if (ev[cyc] || ez[cyc]) begin
        checks++;
        if (bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
          errors++;
          $display("FAIL trivial_data cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc,
                   bus.out_real, bus.out_imag, er[cyc], ei[cyc]);
        end
      end
    end
  endtask

  // Places each probe value at a chosen phase inside a full 8-sample frame.
  task automatic test_phase(input string name, input int pos, input int vr[], input int vi[]);
    for (int f = 0; f < vr.size(); f++) begin
      for (int n = 0; n < 8; n++) begin
        if (n == pos) tick(1'b0, 1'b1, vr[f], vi[f]);
        else tick(1'b0, 1'b1, rnd_s(), rnd_s());
        checks++;
        if (bus.out_valid !== ev[cyc]) begin
          errors++;
          $display("FAIL %s_valid cyc=%0d got %b exp %b", name, cyc, bus.out_valid, ev[cyc]);
        end
        if (ev[cyc] || ez[cyc]) begin
          checks++;
          if (bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
            errors++;
            $display("FAIL %s_data cyc=%0d got (%0d,%0d) exp (%0d,%0d)", name, cyc,
                     bus.out_real, bus.out_imag, er[cyc], ei[cyc]);
          end
        end
      end
    end
  endtask

  task automatic test_rounding();
    int vr[] = '{1000, 0, -1};
    int vi[] = '{0, 1000, -1};
    test_phase("round_k5", 5, vr, vi);
  endtask

  task automatic test_saturation();
    int vr[] = '{-8192, 8191};
    int vi[] = '{5, -8192};
    test_phase("sat_k6", 6, vr, vi);
  endtask

  task automatic test_gapped();
    for (int n = 0; n < 18; n++) begin
      tick(1'b0, (n < 16) && ((n % 4) < 2), rnd_s(), rnd_s());
      checks++;
      if (bus.out_valid !== ev[cyc]) begin
        errors++;
        $display("FAIL gapped_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, ev[cyc]);
      end
      if (ev[cyc] || ez[cyc]) begin
        checks++;
        if (bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
          errors++;
          $display("FAIL gapped_data cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc,
                   bus.out_real, bus.out_imag, er[cyc], ei[cyc]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 16; n++) begin
      // Five samples take the phase to k=5; the reset lands there with a sample offered.
      tick(n == 5, n < 14, rnd_s(), rnd_s());
      checks++;
      if (bus.out_valid !== ev[cyc]) begin
        errors++;
        $display("FAIL midreset_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, ev[cyc]);
      end
      if (ev[cyc] || ez[cyc]) begin
        checks++;
        if (bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
          errors++;
          $display("FAIL midreset_data cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc,
                   bus.out_real, bus.out_imag, er[cyc], ei[cyc]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, rnd_s(), rnd_s());
      checks++;
      if (bus.out_valid !== ev[cyc]) begin
        errors++;
        $display("FAIL random_valid cyc=%0d got %b exp %b", cyc, bus.out_valid, ev[cyc]);
      end
      if (ev[cyc] || ez[cyc]) begin
        checks++;
        if (bus.out_real !== er[cyc] || bus.out_imag !== ei[cyc]) begin
          errors++;
          $display("FAIL random_data cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc,
                   bus.out_real, bus.out_imag, er[cyc], ei[cyc]);
        end
      end
    end
  endtask

  initial begin
    bus.cnt_en  = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    test_reset();
    test_trivial();
    test_rounding();
    test_saturation();
    test_gapped();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
